// File: rtl/nios_onchip_arb_pkg.sv
// ---------------------------------------------------------------------------
// nios_onchip_arb_pkg
// Shared types and defaults for the two-requester on-chip RAM arbiter:
//   DEF_* default widths (2048 x 32 RAM), arbitration state enum,
//   requester id type, and small helper functions (state for an owner id,
//   saturating 32-bit increment used by the optional statistics block).
// ---------------------------------------------------------------------------
package nios_onchip_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_BE_W     = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;
  // hold counter width: enough for MAX_HOLD up to 255
  localparam int unsigned HOLD_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t ID_M0 = 1'b0;
  localparam req_id_t ID_M1 = 1'b1;

  // Ownership state that corresponds to a requester id.
  function automatic arb_state_t own_state(input req_id_t id);
    if (id == ID_M1) begin
      return OWN1;
    end else begin
      return OWN0;
    end
  endfunction

  // Increment when enabled, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/nios_system_onchip_arb_stats.sv
// ---------------------------------------------------------------------------
// nios_system_onchip_arb_stats
// Saturating activity counters for the on-chip RAM arbiter.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   stat_clear_i        synchronous clear of all counters
//   grant0_i/grant1_i   one accepted transfer for m0 / m1 this cycle
//   stall_i             a request saw waitrequest = 1 this cycle
//   grants0_o/grants1_o accepted transfers per requester
//   stalls_o            stalled request cycles
// ---------------------------------------------------------------------------
module nios_system_onchip_arb_stats
  import nios_onchip_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stat_clear_i,
  input  logic        grant0_i,
  input  logic        grant1_i,
  input  logic        stall_i,
  output logic [31:0] grants0_o,
  output logic [31:0] grants1_o,
  output logic [31:0] stalls_o
);

  logic [31:0] grants0_q, grants0_d;
  logic [31:0] grants1_q, grants1_d;
  logic [31:0] stalls_q,  stalls_d;

  // Next counter values: clear wins over counting.
  always_comb begin
    grants0_d = grants0_q;
    grants1_d = grants1_q;
    stalls_d  = stalls_q;
    if (stat_clear_i) begin
      grants0_d = 32'd0;
      grants1_d = 32'd0;
      stalls_d  = 32'd0;
    end else begin
      grants0_d = sat_inc32(grants0_q, grant0_i);
      grants1_d = sat_inc32(grants1_q, grant1_i);
      stalls_d  = sat_inc32(stalls_q,  stall_i);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grants0_q <= 32'd0;
      grants1_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      grants0_q <= grants0_d;
      grants1_q <= grants1_d;
      stalls_q  <= stalls_d;
    end
  end

  assign grants0_o = grants0_q;
  assign grants1_o = grants1_q;
  assign stalls_o  = stalls_q;

endmodule

// File: rtl/nios_system_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nios_system_onchip_mem_arbiter
// Shares port s1 of the on-chip RAM between Avalon-MM requesters m0 and m1.
// Sticky ownership: the owner keeps the RAM while it requests, but once the
// other requester has waited through MAX_HOLD of the owner's grants, the
// bus is handed over. Grants are combinational from state + requests; read
// data returns to the originator one cycle after its grant.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mX_address/byteenable/read/write/writedata   requester X command
//   mX_waitrequest                high = not accepted this cycle
//   mX_readdata/readdatavalid     read response to requester X
//   mem_address/byteenable/chipselect/write/writedata  to RAM s1
//   mem_readdata                  RAM read data (one cycle after address)
// Optional (macro ONCHIP_ARB_STATS_EN):
//   stat_clear                    synchronous clear of the counters
//   stat_grants0/stat_grants1     accepted transfers per requester
//   stat_stalls                   cycles in which a request was stalled
// ---------------------------------------------------------------------------
module nios_system_onchip_mem_arbiter
  import nios_onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BE_W     = DEF_BE_W,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_ARB_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [31:0]       stat_grants0,
  output logic [31:0]       stat_grants1,
  output logic [31:0]       stat_stalls
`endif
);

  // Last grant the owner may take while the other side waits.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);

  arb_state_t          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  req_id_t             last_owner_q, last_owner_d;
  logic                rd_pend_q, rd_pend_d;
  req_id_t             rd_id_q, rd_id_d;

  logic                req0_s, req1_s;
  logic                gnt_vld_s;
  req_id_t             gnt_id_s;
  logic                other_req_s;
  logic [HOLD_W-1:0]   base_hold_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [BE_W-1:0]     sel_be_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_read_s, sel_write_s;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // Grant decision. Gated by reset_n so nothing is accepted while in reset
  // even though the requests are sampled combinationally.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = ID_M0;
    if (reset_n && (req0_s || req1_s)) begin
      gnt_vld_s = 1'b1;
      case (state_q)
        OWN0: begin
          if (req0_s) begin
            gnt_id_s = ID_M0;
          end else begin
            gnt_id_s = ID_M1;
          end
        end
        OWN1: begin
          if (req1_s) begin
            gnt_id_s = ID_M1;
          end else begin
            gnt_id_s = ID_M0;
          end
        end
        IDLE: begin
          // tie goes to whoever was not served last
          if (req0_s && req1_s) begin
            gnt_id_s = ~last_owner_q;
          end else if (req0_s) begin
            gnt_id_s = ID_M0;
          end else begin
            gnt_id_s = ID_M1;
          end
        end
        default: begin
          if (req0_s) begin
            gnt_id_s = ID_M0;
          end else begin
            gnt_id_s = ID_M1;
          end
        end
      endcase
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // Command mux from the granted requester.
  always_comb begin
    sel_addr_s  = m0_address;
    sel_be_s    = m0_byteenable;
    sel_wdata_s = m0_writedata;
    sel_read_s  = m0_read;
    sel_write_s = m0_write;
    if (gnt_id_s == ID_M1) begin
      sel_addr_s  = m1_address;
      sel_be_s    = m1_byteenable;
      sel_wdata_s = m1_writedata;
      sel_read_s  = m1_read;
      sel_write_s = m1_write;
    end else begin
      sel_addr_s  = m0_address;
      sel_be_s    = m0_byteenable;
      sel_wdata_s = m0_writedata;
      sel_read_s  = m0_read;
      sel_write_s = m0_write;
    end
  end

  // Next ownership state, hold count and last owner.
  // hold_q counts grants the current owner has already taken while the other
  // requester waited; a grant to a new owner starts from zero.
  always_comb begin
    state_d      = IDLE;
    hold_d       = {HOLD_W{1'b0}};
    last_owner_d = last_owner_q;
    other_req_s  = 1'b0;
    base_hold_s  = {HOLD_W{1'b0}};
    if (gnt_vld_s) begin
      last_owner_d = gnt_id_s;
      if (gnt_id_s == ID_M1) begin
        other_req_s = req0_s;
      end else begin
        other_req_s = req1_s;
      end
      if (state_q == own_state(gnt_id_s)) begin
        base_hold_s = hold_q;
      end else begin
        base_hold_s = {HOLD_W{1'b0}};
      end
      if (other_req_s && (base_hold_s == HOLD_LAST)) begin
        // this was the owner's last grant; the waiter takes over next
        state_d = own_state(~gnt_id_s);
        hold_d  = {HOLD_W{1'b0}};
      end else if (other_req_s) begin
        state_d = own_state(gnt_id_s);
        hold_d  = base_hold_s + {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
        state_d = own_state(gnt_id_s);
        hold_d  = {HOLD_W{1'b0}};
      end
    end else begin
      state_d = IDLE;
      hold_d  = {HOLD_W{1'b0}};
    end
  end

  // Read tracking: remember that a read was granted and for whom.
  always_comb begin
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (gnt_vld_s && sel_read_s && !sel_write_s) begin
      rd_pend_d = 1'b1;
      rd_id_d   = gnt_id_s;
    end else begin
      rd_pend_d = 1'b0;
    end
  end

  // Arbitration and read-tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= {HOLD_W{1'b0}};
      last_owner_q <= ID_M1;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= ID_M0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
    end
  end

  // RAM-side command and requester handshakes.
  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (gnt_vld_s) begin
      mem_address    = sel_addr_s;
      mem_byteenable = sel_be_s;
      mem_writedata  = sel_wdata_s;
      mem_chipselect = 1'b1;
      mem_write      = sel_write_s;
      m0_waitrequest = (gnt_id_s != ID_M0);
      m1_waitrequest = (gnt_id_s != ID_M1);
    end else begin
      mem_chipselect = 1'b0;
    end
  end

  // Read response steering: registered select, RAM data passed straight through.
  always_comb begin
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    m0_readdata      = {DATA_W{1'b0}};
    m1_readdata      = {DATA_W{1'b0}};
    if (rd_pend_q && (rd_id_q == ID_M1)) begin
      m1_readdatavalid = 1'b1;
      m1_readdata      = mem_readdata;
    end else if (rd_pend_q) begin
      m0_readdatavalid = 1'b1;
      m0_readdata      = mem_readdata;
    end else begin
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
    end
  end

`ifdef ONCHIP_ARB_STATS_EN
  logic gnt0_s, gnt1_s, stall_s;

  assign gnt0_s  = gnt_vld_s & (gnt_id_s == ID_M0);
  assign gnt1_s  = gnt_vld_s & (gnt_id_s == ID_M1);
  assign stall_s = (req0_s & m0_waitrequest) | (req1_s & m1_waitrequest);

  nios_system_onchip_arb_stats u_stats (
    .clk          (clk),
    .reset_n      (reset_n),
    .stat_clear_i (stat_clear),
    .grant0_i     (gnt0_s),
    .grant1_i     (gnt1_s),
    .stall_i      (stall_s),
    .grants0_o    (stat_grants0),
    .grants1_o    (stat_grants1),
    .stalls_o     (stat_stalls)
  );
`endif

endmodule

// File: tb/tb_nios_system_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nios_system_onchip_mem_arbiter
// Directed bench with a behavioural RAM, two queue-driven Avalon requesters,
// an arbitration reference model checked every cycle, and literal checks on
// grant order, read data and stall counts. MAX_HOLD is set to 4.
// ---------------------------------------------------------------------------
module tb_nios_system_onchip_mem_arbiter;

  localparam int HOLD = 4;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] m0_address = 11'd0, m1_address = 11'd0;
  logic [3:0]  m0_byteenable = 4'd0, m1_byteenable = 4'd0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = 32'd0, m1_writedata = 32'd0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'd0;
`ifdef ONCHIP_ARB_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_grants0, stat_grants1, stat_stalls;
`endif

  always #5 clk = ~clk;

  nios_system_onchip_mem_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
`ifdef ONCHIP_ARB_STATS_EN
    .stat_clear       (stat_clear),
    .stat_grants0     (stat_grants0),
    .stat_grants1     (stat_grants1),
    .stat_stalls      (stat_stalls),
`endif
    .mem_readdata     (mem_readdata)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [15:0] a;
    a = 16'(i);
    return {16'hC0DE ^ a, 16'h1234 + a};
  endfunction

  function automatic txn_t rd_t(input logic [10:0] a);
    txn_t t;
    t = '0; t.rd = 1'b1; t.addr = a; t.be = 4'hF;
    return t;
  endfunction

  function automatic txn_t wr_t(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    txn_t t;
    t = '0; t.wr = 1'b1; t.addr = a; t.be = be; t.wd = d;
    return t;
  endfunction

  // ---------------- RAM behind s1 (DUT side) and model copy ----------------
  logic [31:0] ram  [0:2047];
  logic [31:0] mref [0:2047];
  logic [31:0] ram_w;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]  = init_word(i);
      mref[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      ram_w = ram[mem_address];
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram_w[8*b +: 8] = mem_writedata[8*b +: 8];
      ram[mem_address] <= ram_w;
    end else if (mem_chipselect) begin
      mem_readdata <= ram[mem_address];
    end
  end

  // ---------------- requesters ----------------
  txn_t q0[$], q1[$];
  txn_t t0 = '0, t1 = '0;
  bit   pres0 = 1'b0, pres1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0;

  initial begin : drv
    forever begin
      @(posedge clk); #1;
      if (!pres0 || acc0) begin
        if (q0.size() > 0) begin t0 = q0.pop_front(); pres0 = 1'b1; end
        else begin t0 = '0; pres0 = 1'b0; end
      end
      if (!pres1 || acc1) begin
        if (q1.size() > 0) begin t1 = q1.pop_front(); pres1 = 1'b1; end
        else begin t1 = '0; pres1 = 1'b0; end
      end
      m0_read = t0.rd; m0_write = t0.wr; m0_address = t0.addr;
      m0_byteenable = t0.be; m0_writedata = t0.wd;
      m1_read = t1.rd; m1_write = t1.wr; m1_address = t1.addr;
      m1_byteenable = t1.be; m1_writedata = t1.wd;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Model: the current owner keeps the RAM until it has taken HOLD grants in a
  // row with the other side waiting; ties from idle go to the one not served last.
  int owner = -1, streak = 0, last = 1, g = -1, cyc = 0;
  bit p_vld = 1'b0; int p_id = 0; logic [31:0] p_data = 32'd0;
  bit r0, r1, contested;
  txn_t gt;
  logic [31:0] w;
  logic [46:0] e_cmd;
  int gseq[$], gcyc[$];
  int stall0 = 0, stall1 = 0, rdv0_cnt = 0, rdv1_cnt = 0;
  logic [31:0] last_rd0 = 32'd0, last_rd1 = 32'd0;

  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      // read responses from the previous cycle's grant
      chk("rdv0", m0_readdatavalid, reset_n && p_vld && p_id == 0);
      chk("rdv1", m1_readdatavalid, reset_n && p_vld && p_id == 1);
      chk("rdata0", m0_readdata, (reset_n && p_vld && p_id == 0) ? p_data : 32'd0);
      chk("rdata1", m1_readdata, (reset_n && p_vld && p_id == 1) ? p_data : 32'd0);
      // who must be granted now
      if (!reset_n || (!r0 && !r1)) g = -1;
      else if (r0 && !r1) g = 0;
      else if (r1 && !r0) g = 1;
      else if (owner < 0) g = 1 - last;
      else if (streak >= HOLD) g = 1 - owner;
      else g = owner;
      gt = (g == 1) ? t1 : t0;
      e_cmd = (g >= 0) ? {gt.addr, gt.be, gt.wd} : 47'd0;
      chk("waitreq0", m0_waitrequest, g != 0);
      chk("waitreq1", m1_waitrequest, g != 1);
      chk("chipsel", mem_chipselect, g >= 0);
      chk("memwrite", mem_write, (g >= 0) && gt.wr);
      chk("memcmd", {mem_address, mem_byteenable, mem_writedata}, e_cmd);
      // observations for the directed literal checks
      if (!m0_waitrequest) begin gseq.push_back(0); gcyc.push_back(cyc); end
      if (!m1_waitrequest) begin gseq.push_back(1); gcyc.push_back(cyc); end
      if (reset_n && r0 && m0_waitrequest) stall0++;
      if (reset_n && r1 && m1_waitrequest) stall1++;
      if (m0_readdatavalid) begin rdv0_cnt++; last_rd0 = m0_readdata; end
      if (m1_readdatavalid) begin rdv1_cnt++; last_rd1 = m1_readdata; end
      acc0 = pres0 && (!r0 || !m0_waitrequest);
      acc1 = pres1 && (!r1 || !m1_waitrequest);
      // advance the model
      p_vld = 1'b0;
      if (!reset_n) begin
        owner = -1; streak = 0; last = 1;
      end else if (g >= 0) begin
        contested = (g == 0) ? r1 : r0;
        if (!contested) streak = 0;
        else if (g == owner) streak++;
        else streak = 1;
        owner = g; last = g;
        if (gt.wr) begin
          w = mref[gt.addr];
          for (int b = 0; b < 4; b++)
            if (gt.be[b]) w[8*b +: 8] = gt.wd[8*b +: 8];
          mref[gt.addr] = w;
        end else begin
          p_vld = 1'b1; p_id = g; p_data = mref[gt.addr];
        end
      end else begin
        owner = -1; streak = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clr_obs();
    @(posedge clk);
    gseq.delete(); gcyc.delete();
    stall0 = 0; stall1 = 0; rdv0_cnt = 0; rdv1_cnt = 0;
    last_rd0 = 32'd0; last_rd1 = 32'd0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pres0 || pres1) && n < 300) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s timeout actual=%0d cycles required<300", nm, n);
    end
    repeat (3) @(negedge clk);
  endtask

  int exp_seq[20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};

  initial begin : stim
    int n;
    // reset held with m0 already reading word 0
    q0.push_back(rd_t(11'h000));
    repeat (3) @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_wait1", m1_waitrequest, 1'b1);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_rdv0", m0_readdatavalid, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_grant0", m0_waitrequest, 1'b0);
    @(negedge clk);
    chk("rel_rdv0", m0_readdatavalid, 1'b1);
    chk("rel_rdata0", m0_readdata, 32'hC0DE1234);
    wait_idle("t_reset");

    // m1 writes low half of 0x7FF, then reads it back
    do_reset(); clr_obs();
    q1.push_back(wr_t(11'h7FF, 4'h3, 32'hDEADBEEF));
    q1.push_back(rd_t(11'h7FF));
    wait_idle("t_wr_rd");
    chk("wr_rd_data1", last_rd1, 32'hC721BEEF);
    chk("wr_rd_rdv1_cnt", rdv1_cnt, 1);
    chk("wr_rd_rdv0_cnt", rdv0_cnt, 0);

    // simultaneous first requests after reset
    do_reset(); clr_obs();
    q0.push_back(rd_t(11'h010));
    q1.push_back(rd_t(11'h020));
    wait_idle("t_simul");
    chk("simul_n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("simul_first", gseq[0], 0);
      chk("simul_second", gseq[1], 1);
    end
    chk("simul_rd0", last_rd0, 32'hC0CE1244);
    chk("simul_rd1", last_rd1, 32'hC0FE1254);

    // hold limit with both streaming
    do_reset(); clr_obs();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(rd_t(11'(11'h100 + i)));
      q1.push_back(rd_t(11'(11'h200 + i)));
    end
    wait_idle("t_hold");
    chk("hold_n", gseq.size(), 20);
    if (gseq.size() == 20)
      for (int i = 0; i < 20; i++) chk($sformatf("hold_seq%0d", i), gseq[i], exp_seq[i]);
    chk("hold_stall0", stall0, 8);
    chk("hold_stall1", stall1, 10);
    chk("hold_rdv0", rdv0_cnt, 10);
    chk("hold_rdv1", rdv1_cnt, 10);
`ifdef ONCHIP_ARB_STATS_EN
    chk("stat_g0", stat_grants0, 32'd10);
    chk("stat_g1", stat_grants1, 32'd10);
    chk("stat_st", stat_stalls, 32'd18);
`endif

    // owner drops its request while m1 waits
    do_reset(); clr_obs();
    q0.push_back(rd_t(11'h300));
    q0.push_back(rd_t(11'h301));
    q1.push_back(rd_t(11'h310));
    wait_idle("t_drop");
    chk("drop_n", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("drop_seq", {gseq[0][1:0], gseq[1][1:0], gseq[2][1:0]}, 6'b00_00_01);
      chk("drop_nobubble", gcyc[2] - gcyc[1], 1);
    end
    chk("drop_stall1", stall1, 2);

    // reset arrives the cycle after an m0 read grant
    do_reset(); clr_obs();
    q0.push_back(rd_t(11'h005));
    n = 0;
    do begin @(negedge clk); n++; end while (m0_waitrequest && n < 50);
    chk("mid_granted", m0_waitrequest, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rdv0", m0_readdatavalid, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rdv0_cnt", rdv0_cnt, 0);
`ifdef ONCHIP_ARB_STATS_EN
    chk("mid_stat_g0", stat_grants0, 32'd0);
    chk("mid_stat_g1", stat_grants1, 32'd0);
    chk("mid_stat_st", stat_stalls, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
